// File: rtl/sm4_decrypt_iter.sv
// Iterative SM4 block decryptor: expands the master key into 32 on-chip round keys,
// then runs 32 decryption rounds consuming them in reverse order.

module sbox_replace (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   assign o_byte = SBOX[i_byte];

endmodule

module sm4_decrypt_iter #(
   parameter bit KEY_CACHE = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key_in,
   input  logic [127:0] cipher_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plain_out,
   output logic         busy
);

   localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

   typedef enum logic [1:0] {
      S_IDLE,
      S_KEYEXP,
      S_DECRYPT,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_stateNext;
   logic [4:0]    r_round;
   logic          r_primed;
   logic [31:0]   r_k0, r_k1, r_k2, r_k3;
   logic [31:0]   r_x0, r_x1, r_x2, r_x3;
   logic [127:0]  r_key;
   logic [127:0]  r_cacheKey;
   logic          r_cacheValid;
   logic [31:0]   r_rkMem [32];
   logic [31:0]   r_rkCur;
   logic [127:0]  r_plain;
   logic          r_outValid;

   logic          w_accept;
   logic          w_hit;
   logic          w_lastRound;
   logic [31:0]   w_ck;
   logic [31:0]   w_kMix, w_kSub, w_kNew;
   logic [31:0]   w_xMix, w_xSub, w_xNew;

   function automatic logic [31:0] rotl32(input logic [31:0] b, input int unsigned n);
      return (b << n) | (b >> (32 - n));
   endfunction

   assign in_ready    = (r_state == S_IDLE) && !rst;
   assign w_accept    = in_valid && in_ready;
   assign w_hit       = KEY_CACHE && r_cacheValid && (key_in == r_cacheKey);
   assign w_lastRound = (r_round == 5'd31);

   assign w_kMix = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;
   assign w_kNew = r_k0 ^ w_kSub ^ rotl32(w_kSub, 13) ^ rotl32(w_kSub, 23);
   assign w_xMix = r_x1 ^ r_x2 ^ r_x3 ^ r_rkCur;
   assign w_xNew = r_x0 ^ w_xSub ^ rotl32(w_xSub, 2) ^ rotl32(w_xSub, 10)
                 ^ rotl32(w_xSub, 18) ^ rotl32(w_xSub, 24);

   // Per byte lane: the CK constant byte, the key-schedule S-box and the round S-box.
   for (genvar j = 0; j < 4; j++) begin : g_byte
      logic [7:0] w_ckIdx;
      assign w_ckIdx = {1'b0, r_round, 2'(j)};
      assign w_ck[31-8*j -: 8] = w_ckIdx * 8'd7;

      sbox_replace u_sboxKey (
         .i_byte (w_kMix[31-8*j -: 8]),
         .o_byte (w_kSub[31-8*j -: 8])
      );

      sbox_replace u_sboxRnd (
         .i_byte (w_xMix[31-8*j -: 8]),
         .o_byte (w_xSub[31-8*j -: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_stateNext;
   end

   // Decryption leaves only after the priming cycle plus 32 rounds have completed.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_stateNext = w_hit ? S_DECRYPT : S_KEYEXP;
         S_KEYEXP:  if (w_lastRound) w_stateNext = S_DECRYPT;
         S_DECRYPT: if (r_primed && w_lastRound) w_stateNext = S_DONE;
         S_DONE:    if (out_ready) w_stateNext = S_IDLE;
         default:   w_stateNext = S_IDLE;
      endcase
   end

   // Round keys are read one cycle ahead, so DECRYPT spends its first cycle fetching rk31.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_round      <= 5'd0;
         r_primed     <= 1'b0;
         r_k0         <= 32'd0;
         r_k1         <= 32'd0;
         r_k2         <= 32'd0;
         r_k3         <= 32'd0;
         r_x0         <= 32'd0;
         r_x1         <= 32'd0;
         r_x2         <= 32'd0;
         r_x3         <= 32'd0;
         r_key        <= 128'd0;
         r_cacheKey   <= 128'd0;
         r_cacheValid <= 1'b0;
         r_rkCur      <= 32'd0;
         r_plain      <= 128'd0;
         r_outValid   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_key                    <= key_in;
                  {r_x0, r_x1, r_x2, r_x3} <= cipher_in;
                  {r_k0, r_k1, r_k2, r_k3} <= key_in ^ FK;
                  r_round                  <= 5'd0;
                  r_primed                 <= 1'b0;
               end
            end
            S_KEYEXP: begin
               r_k0    <= r_k1;
               r_k1    <= r_k2;
               r_k2    <= r_k3;
               r_k3    <= w_kNew;
               r_round <= r_round + 5'd1;
               if (w_lastRound) begin
                  r_cacheKey   <= r_key;
                  r_cacheValid <= 1'b1;
               end
            end
            S_DECRYPT: begin
               if (!r_primed) begin
                  r_primed <= 1'b1;
                  r_rkCur  <= r_rkMem[5'd31];
               end else begin
                  r_x0    <= r_x1;
                  r_x1    <= r_x2;
                  r_x2    <= r_x3;
                  r_x3    <= w_xNew;
                  r_round <= r_round + 5'd1;
                  r_rkCur <= r_rkMem[5'd30 - r_round];
                  if (w_lastRound) begin
                     r_plain    <= {w_xNew, r_x3, r_x2, r_x1};
                     r_outValid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) r_outValid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && r_state == S_KEYEXP) r_rkMem[r_round] <= w_kNew;
   end

   assign out_valid = r_outValid;
   assign plain_out = r_plain;
   assign busy      = (r_state == S_KEYEXP) || (r_state == S_DECRYPT);

endmodule

// File: tb/tb_sm4_decrypt_iter.sv
// Directed bench for sm4_decrypt_iter: standard vector, key cache, backpressure,
// ignored input, mid-flight reset and blocks encrypted by an independent reference model.

module tb_sm4_decrypt_iter;

   localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] STD_CT  = 128'h681EDF34D206965E86B3E94F536E4246;
   localparam logic [127:0] STD_PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] FK      = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_valid0;
   logic [127:0] key_in, cipher_in;
   logic         out_ready, out_ready0;
   logic         in_ready, in_ready0;
   logic         out_valid, out_valid0;
   logic [127:0] plain_out, plain_out0;
   logic         busy, busy0;

   int nVec  = 0;
   int nMiss = 0;

   sm4_decrypt_iter #(.KEY_CACHE(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key_in    (key_in),
      .cipher_in (cipher_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .plain_out (plain_out),
      .busy      (busy)
   );

   sm4_decrypt_iter #(.KEY_CACHE(1'b0)) dutNoCache (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .key_in    (key_in),
      .cipher_in (cipher_in),
      .out_valid (out_valid0),
      .out_ready (out_ready0),
      .plain_out (plain_out0),
      .busy      (busy0)
   );

   always #5 clk = ~clk;

   // Reference encryption, used only to build ciphertexts for random blocks.
   function automatic logic [31:0] rotl32(input logic [31:0] b, input int unsigned n);
      return (b << n) | (b >> (32 - n));
   endfunction

   function automatic logic [31:0] tauModel(input logic [31:0] a);
      return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
   endfunction

   function automatic logic [127:0] sm4Encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0] k [36];
      logic [31:0] x [36];
      logic [31:0] rk [32];
      logic [31:0] ck, b;
      logic [127:0] kf;
      kf = key ^ FK;
      {k[0], k[1], k[2], k[3]} = kf;
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
         b = tauModel(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
         k[i+4] = k[i] ^ b ^ rotl32(b, 13) ^ rotl32(b, 23);
         rk[i] = k[i+4];
      end
      {x[0], x[1], x[2], x[3]} = pt;
      for (int i = 0; i < 32; i++) begin
         b = tauModel(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[i]);
         x[i+4] = x[i] ^ b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      nVec++;
      assert (observed === expected) else begin
         nMiss++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Waits for in_ready, then presents one block for a single accept edge (cycle 0).
   task automatic applyStimulus(input bit which, input logic [127:0] key, input logic [127:0] ct);
      int n = 0;
      @(negedge clk);
      while (!(which ? in_ready0 : in_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready before submit", which ? in_ready0 : in_ready, 1);
      key_in    = key;
      cipher_in = ct;
      if (which) in_valid0 = 1'b1;
      else       in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_valid0 = 1'b0;
      checkOutput("busy after accept", which ? busy0 : busy, 1);
      checkOutput("in_ready after accept", which ? in_ready0 : in_ready, 0);
   endtask

   task automatic waitOut(input bit which, input int startCyc, input int expCyc, input string tag);
      int  cyc  = startCyc;
      bit  seen = 1'b0;
      while (!seen && cyc < startCyc + 200) begin
         @(posedge clk);
         #1;
         cyc++;
         seen = which ? out_valid0 : out_valid;
      end
      checkOutput(tag, cyc, expCyc);
   endtask

   task automatic finishHandshake(input int stall, input logic [127:0] exp, input string tag);
      repeat (stall) begin
         @(negedge clk);
         checkOutput({tag, " stall out_valid"}, out_valid, 1);
         checkOutput({tag, " stall plain_out"}, plain_out, exp);
         checkOutput({tag, " stall in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, " out_valid after handshake"}, out_valid, 0);
      checkOutput({tag, " in_ready after handshake"}, in_ready, 1);
      checkOutput({tag, " plain_out retained"}, plain_out, exp);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] key, prevKey, pt, ct;
      bit hit;

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_valid0  = 1'b0;
      out_ready  = 1'b0;
      out_ready0 = 1'b1;
      key_in     = '0;
      cipher_in  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset plain_out", plain_out, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("in_ready after reset", in_ready, 1);

      // Standard vector with full key expansion
      applyStimulus(0, STD_KEY, STD_CT);
      waitOut(0, 0, 65, "latency std expand");
      checkOutput("std plaintext", plain_out, STD_PT);
      finishHandshake(0, STD_PT, "std");

      // Same key again: cache hit, then 10-cycle out_ready stall
      applyStimulus(0, STD_KEY, STD_CT);
      waitOut(0, 0, 33, "latency std cache hit");
      checkOutput("cache hit plaintext", plain_out, STD_PT);
      finishHandshake(10, STD_PT, "stall10");

      // in_valid pulse with different data during DECRYPT is ignored
      applyStimulus(0, STD_KEY, STD_CT);
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("busy during decrypt", busy, 1);
      key_in    = 128'hDEADBEEF_00000000_11111111_CAFEF00D;
      cipher_in = 128'h55555555_AAAAAAAA_12345678_9ABCDEF0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitOut(0, 6, 33, "latency with ignored pulse");
      checkOutput("ignored pulse plaintext", plain_out, STD_PT);
      finishHandshake(1, STD_PT, "pulse");

      // Reset at cycle 20 of KEYEXP, then the standard vector must re-expand
      applyStimulus(0, 128'h00112233445566778899AABBCCDDEEFF, STD_CT);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid reset out_valid", out_valid, 0);
      checkOutput("mid reset busy", busy, 0);
      checkOutput("mid reset in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("in_ready after mid reset", in_ready, 1);
      applyStimulus(0, STD_KEY, STD_CT);
      waitOut(0, 0, 65, "latency after reset no cache");
      checkOutput("plaintext after reset", plain_out, STD_PT);
      finishHandshake(0, STD_PT, "post reset");

      // KEY_CACHE=0 instance always expands
      applyStimulus(1, STD_KEY, STD_CT);
      waitOut(1, 0, 65, "nocache latency first");
      checkOutput("nocache plaintext first", plain_out0, STD_PT);
      applyStimulus(1, STD_KEY, STD_CT);
      waitOut(1, 0, 65, "nocache latency repeat");
      checkOutput("nocache plaintext repeat", plain_out0, STD_PT);

      // Random blocks from the reference encryptor, with key reuse and random stalls
      prevKey = STD_KEY;
      for (int i = 0; i < 24; i++) begin
         hit = (i % 3 == 2);
         key = hit ? prevKey : {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         ct  = sm4Encrypt(key, pt);
         applyStimulus(0, key, ct);
         waitOut(0, 0, hit ? 33 : 65, "random latency");
         checkOutput("random plaintext", plain_out, pt);
         finishHandshake(int'($urandom_range(0, 3)), pt, "random");
         prevKey = key;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
